// File: rtl/stack_pkg.sv
// Shared types and width helpers for the multi-context stack.
package stack_pkg;

  typedef enum logic [1:0] {
    OP_NOP,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } stack_op_e;

  // Map the raw {push,pop} command bits to a stack operation.
  function automatic stack_op_e decode_op(input logic push, input logic pop);
    case ({push, pop})
      2'b10:   return OP_PUSH;
      2'b01:   return OP_POP;
      2'b11:   return OP_REPLACE;
      default: return OP_NOP;
    endcase
  endfunction

  // Index width for n items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return idx_width(depth) + 1;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// Simple dual-port storage: one write, one registered read, read-first on collision.
module stack_ram #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned ENTRIES = 1 << ADDR_W;

  logic [DATA_WIDTH-1:0] mem [ENTRIES];

  // Write and read share the edge; the read samples the pre-write contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/multi_ctx_stack.sv
// NUM_CTX independent LIFO stacks sharing one RAM, one command per cycle.
module multi_ctx_stack
  import stack_pkg::*;
#(
  parameter  int unsigned NUM_CTX    = 4,
  parameter  int unsigned DEPTH      = 64,
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned CTX_W      = idx_width(NUM_CTX),
  localparam int unsigned PTR_W      = idx_width(DEPTH),
  localparam int unsigned CNT_W      = count_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  input  logic [CTX_W-1:0]      cmd_ctx,
  input  logic                  cmd_push,
  input  logic                  cmd_pop,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic                  flush_valid,
  input  logic [CTX_W-1:0]      flush_ctx,
  input  logic                  err_clear,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic [CNT_W-1:0]      sel_count,
  output logic [NUM_CTX-1:0]    full,
  output logic [NUM_CTX-1:0]    empty,
  output logic [NUM_CTX-1:0]    ovf_err,
  output logic [NUM_CTX-1:0]    unf_err
);

  localparam int unsigned ADDR_W = CTX_W + PTR_W;

  logic [CNT_W-1:0]      count [NUM_CTX];
  logic [CNT_W-1:0]      cnt_sel;
  logic                  sel_empty;
  logic                  sel_full;
  logic                  cmd_blocked;
  stack_op_e             op;
  logic [PTR_W-1:0]      ptr_push;
  logic [PTR_W-1:0]      ptr_top;

  logic                  ram_we;
  logic                  ram_re;
  logic [ADDR_W-1:0]     ram_waddr;
  logic [ADDR_W-1:0]     ram_raddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic                  cnt_inc;
  logic                  cnt_dec;
  logic [NUM_CTX-1:0]    ovf_set;
  logic [NUM_CTX-1:0]    unf_set;
  logic                  rsp_fire;
  logic                  rsp_err_n;
  logic                  bypass_n;

  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic                  bypass_q;
  logic [DATA_WIDTH-1:0] bypass_data_q;
  logic [DATA_WIDTH-1:0] hold_q;

  assign cnt_sel     = count[cmd_ctx];
  assign sel_count   = cnt_sel;
  assign sel_empty   = (cnt_sel == '0);
  assign sel_full    = (cnt_sel == CNT_W'(DEPTH));
  assign ptr_push    = cnt_sel[PTR_W-1:0];
  assign ptr_top     = PTR_W'(cnt_sel - CNT_W'(1));
  // A flush on the same context discards the command entirely.
  assign cmd_blocked = flush_valid && (flush_ctx == cmd_ctx);
  assign op          = (cmd_valid && !cmd_blocked) ? decode_op(cmd_push, cmd_pop) : OP_NOP;

  // Decode the operation into RAM strobes, counter moves, errors and response kind.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = {cmd_ctx, ptr_push};
    ram_raddr = {cmd_ctx, ptr_top};
    ram_wdata = cmd_data;
    cnt_inc   = 1'b0;
    cnt_dec   = 1'b0;
    ovf_set   = '0;
    unf_set   = '0;
    rsp_fire  = 1'b0;
    rsp_err_n = 1'b0;
    bypass_n  = 1'b0;
    case (op)
      OP_PUSH: begin
        if (sel_full) begin
          ovf_set[cmd_ctx] = 1'b1;
        end else begin
          ram_we  = 1'b1;
          cnt_inc = 1'b1;
        end
      end
      OP_POP: begin
        rsp_fire = 1'b1;
        if (sel_empty) begin
          rsp_err_n        = 1'b1;
          unf_set[cmd_ctx] = 1'b1;
        end else begin
          ram_re  = 1'b1;
          cnt_dec = 1'b1;
        end
      end
      OP_REPLACE: begin
        rsp_fire = 1'b1;
        if (sel_empty) begin
          bypass_n = 1'b1;
        end else begin
          // Old top is read and overwritten on the same edge; relies on read-first RAM.
          ram_re    = 1'b1;
          ram_we    = 1'b1;
          ram_waddr = {cmd_ctx, ptr_top};
        end
      end
      default: ;
    endcase
  end

  stack_ram #(
    .ADDR_W    (ADDR_W),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  // Per-context occupancy; flush has priority over any command.
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NUM_CTX; c++) begin
      if (reset) begin
        count[c] <= '0;
      end else if (flush_valid && (flush_ctx == CTX_W'(c))) begin
        count[c] <= '0;
      end else if (cmd_ctx == CTX_W'(c)) begin
        if (cnt_inc)      count[c] <= count[c] + CNT_W'(1);
        else if (cnt_dec) count[c] <= count[c] - CNT_W'(1);
      end
    end
  end

  // Status flags derived from the registered counts.
  always_comb begin
    full  = '0;
    empty = '0;
    for (int unsigned c = 0; c < NUM_CTX; c++) begin
      full[c]  = (count[c] == CNT_W'(DEPTH));
      empty[c] = (count[c] == '0);
    end
  end

  // Sticky error vectors; new errors override a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_err <= '0;
      unf_err <= '0;
    end else begin
      ovf_err <= (err_clear ? '0 : ovf_err) | ovf_set;
      unf_err <= (err_clear ? '0 : unf_err) | unf_set;
    end
  end

  // Response pipeline stage; hold_q keeps the last delivered data between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      bypass_q      <= 1'b0;
      bypass_data_q <= '0;
      hold_q        <= '0;
    end else begin
      rsp_valid_q <= rsp_fire;
      rsp_err_q   <= rsp_err_n;
      bypass_q    <= bypass_n;
      if (bypass_n)    bypass_data_q <= cmd_data;
      if (rsp_valid_q) hold_q        <= rsp_data;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  // RAM output is registered already, so the final data select is combinational.
  assign rsp_data  = !rsp_valid_q ? hold_q :
                     rsp_err_q    ? '0 :
                     bypass_q     ? bypass_data_q : ram_rdata;

endmodule
